rom_dma_fetch_engine: RTL and testbench

- Upstream neighbour of the ROM-data-FIFO consumer that assembles {header, 4 data bytes} instructions for the ll_engine.
- On a start command, reads a contiguous run of instruction bytes from the synchronous instruction ROM and pushes them, in order, into the ROM data FIFO.
- Hides ROM read latency with a skid buffer; never drops or duplicates a byte under FIFO back-pressure.

---
 rtl/rom_dma_fetch_engine.sv | 152 +++++++++++++++
 tb/tb_rom_dma_fetch_engine.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_dma_fetch_engine.sv
// rom_dma_fetch_engine: streams a run of instruction bytes from the sync ROM into the ROM data FIFO
// Optional header check is enabled by defining ROM_DMA_HDR_CHK_EN.
module rom_dma_fetch_engine #(
    parameter int ROM_ADDR_WIDTH              = 10,
    parameter int ROM_FIFO_DATA_WIDTH         = 8,
    parameter int ROM_RD_LATENCY              = 2,
    parameter int NUM_OF_ROM_FIFO_RD_PER_INST = 5,
    parameter int NUM_INST_WIDTH              = 8
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           dma_start,
    input  logic                           dma_abort,
    input  logic [ROM_ADDR_WIDTH-1:0]      dma_base_addr,
    input  logic [NUM_INST_WIDTH-1:0]      dma_num_inst,
    output logic                           dma_busy,
    output logic                           dma_done,
    output logic                           dma_hdr_err,
    output logic                           rom_rd_en,
    output logic [ROM_ADDR_WIDTH-1:0]      rom_addr,
    input  logic [ROM_FIFO_DATA_WIDTH-1:0] rom_rd_data,
    output logic                           rom_data_fifo_fifo_data_push,
    output logic [ROM_FIFO_DATA_WIDTH-1:0] rom_data_fifo_fifo_data_in,
    input  logic                           rom_data_fifo_fifo_full
);
    localparam int TW   = NUM_INST_WIDTH + 3;
    localparam int SKID = ROM_RD_LATENCY + 1;
    localparam int PW   = $clog2(SKID);
    localparam int CW   = $clog2(SKID + 1) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                         state_q, state_d;
    logic [ROM_ADDR_WIDTH-1:0]      base_q, base_d;
    logic [TW-1:0]                  total_q, total_d, issued_q, issued_d;
    logic [ROM_RD_LATENCY-1:0]      vpipe_q, vpipe_d;
    logic [ROM_FIFO_DATA_WIDTH-1:0] skid_q [SKID];
    logic [ROM_FIFO_DATA_WIDTH-1:0] skid_d [SKID];
    logic [PW-1:0]                  wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]                  cnt_q, cnt_d, inflight;
    logic                           wr, push, rd_en, accept, abort;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(SKID - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i < ROM_RD_LATENCY; i++) inflight = inflight + CW'(vpipe_q[i]);
        wr     = vpipe_q[ROM_RD_LATENCY-1];
        push   = (cnt_q != '0) && !rom_data_fifo_fifo_full;
        accept = (state_q == IDLE) && dma_start && !dma_abort;
        abort  = dma_abort && (state_q == RUN || state_q == DRAIN);
        // a byte leaving the skid this cycle frees its slot, keeping 1 byte/cycle
        rd_en  = (state_q == RUN) && (issued_q < total_q) &&
                 (inflight + cnt_q - CW'(push) < CW'(SKID));
        state_d  = state_q;
        base_d   = base_q;
        total_d  = total_q;
        issued_d = issued_q + TW'(rd_en);
        vpipe_d  = (vpipe_q << 1) | ROM_RD_LATENCY'(rd_en);
        skid_d   = skid_q;
        if (wr) skid_d[wp_q] = rom_rd_data;
        wp_d  = wr ? nxt(wp_q) : wp_q;
        rp_d  = push ? nxt(rp_q) : rp_q;
        cnt_d = cnt_q + CW'(wr) - CW'(push);
        case (state_q)
            IDLE: if (accept) begin
                base_d   = dma_base_addr;
                total_d  = TW'(dma_num_inst) * TW'(NUM_OF_ROM_FIFO_RD_PER_INST);
                issued_d = '0;
                state_d  = (dma_num_inst != '0) ? RUN : DONE;
            end
            RUN:     if (rd_en && issued_q == total_q - 1'b1) state_d = DRAIN;
            DRAIN:   if (inflight == '0 && cnt_q == CW'(push)) state_d = DONE;
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
            vpipe_d = '0;
            wp_d    = '0;
            rp_d    = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            base_q   <= '0;
            total_q  <= '0;
            issued_q <= '0;
            vpipe_q  <= '0;
            skid_q   <= '{default: '0};
            wp_q     <= '0;
            rp_q     <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            total_q  <= total_d;
            issued_q <= issued_d;
            vpipe_q  <= vpipe_d;
            skid_q   <= skid_d;
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef ROM_DMA_HDR_CHK_EN
    localparam int MW = $clog2(NUM_OF_ROM_FIFO_RD_PER_INST);

    logic [MW-1:0]                  mod_q, mod_d;
    logic                           err_q, err_d;
    logic [ROM_FIFO_DATA_WIDTH-1:0] head;

    always_comb begin
        head  = skid_q[rp_q];
        mod_d = mod_q;
        err_d = err_q;
        if (push) mod_d = (mod_q == MW'(NUM_OF_ROM_FIFO_RD_PER_INST - 1)) ? '0 : mod_q + 1'b1;
        // legal opcodes are EXP/SIN/COS (0..2) with the top bit clear
        if (push && mod_q == '0 && (head[7] || head[6:4] > 3'd2)) err_d = 1'b1;
        if (accept) begin
            mod_d = '0;
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mod_q <= '0;
            err_q <= 1'b0;
        end else begin
            mod_q <= mod_d;
            err_q <= err_d;
        end
    end

    assign dma_hdr_err = err_q;
`else
    assign dma_hdr_err = 1'b0;
`endif

    assign dma_busy                     = (state_q == RUN) || (state_q == DRAIN);
    assign dma_done                     = (state_q == DONE);
    assign rom_rd_en                    = rd_en;
    assign rom_addr                     = rd_en ? base_q + ROM_ADDR_WIDTH'(issued_q) : '0;
    assign rom_data_fifo_fifo_data_push = push;
    assign rom_data_fifo_fifo_data_in   = skid_q[rp_q];
endmodule

// File: tb/tb_rom_dma_fetch_engine.sv
// tb_rom_dma_fetch_engine: randomized bench for rom_dma_fetch_engine against an address-order byte model
module tb_rom_dma_fetch_engine;
    localparam int AW = 10, DW = 8, LAT = 2, NI = 5, NW = 8;

    logic          clk = 1'b0, reset_n = 1'b0, dma_start = 1'b0, dma_abort = 1'b0, full = 1'b0;
    logic [AW-1:0] dma_base_addr = '0;
    logic [NW-1:0] dma_num_inst = '0;
    logic          dma_busy, dma_done, dma_hdr_err, rom_rd_en, push;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_rd_data = '0, fifo_din;
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [AW-1:0] a1 = '0;

    int            cyc = 0, checks = 0, errors = 0, viol = 0, n_rd = 0, n_push = 0;
    logic          hdr_ever = 1'b0;
    logic [DW-1:0] got[$], exp_q[$];
    logic [AW-1:0] addrs[$], exp_a[$];
    int            push_cyc[$], rd_cyc[$], done_cyc[$];
    logic          hdr_seen[$];

    rom_dma_fetch_engine #(
        .ROM_ADDR_WIDTH(AW), .ROM_FIFO_DATA_WIDTH(DW), .ROM_RD_LATENCY(LAT),
        .NUM_OF_ROM_FIFO_RD_PER_INST(NI), .NUM_INST_WIDTH(NW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .dma_start(dma_start), .dma_abort(dma_abort),
        .dma_base_addr(dma_base_addr), .dma_num_inst(dma_num_inst),
        .dma_busy(dma_busy), .dma_done(dma_done), .dma_hdr_err(dma_hdr_err),
        .rom_rd_en(rom_rd_en), .rom_addr(rom_addr), .rom_rd_data(rom_rd_data),
        .rom_data_fifo_fifo_data_push(push), .rom_data_fifo_fifo_data_in(fifo_din),
        .rom_data_fifo_fifo_full(full)
    );

    always #5 clk = ~clk;

    // synchronous ROM with two-cycle read latency
    always @(posedge clk) begin
        a1          <= rom_addr;
        rom_rd_data <= mem[a1];
        cyc         <= cyc + 1;
    end

    always @(negedge clk) begin
        if (push) begin
            if (full) viol++;
            got.push_back(fifo_din);
            push_cyc.push_back(cyc);
            hdr_seen.push_back(dma_hdr_err);
        end
        if (rom_rd_en) begin
            addrs.push_back(rom_addr);
            rd_cyc.push_back(cyc);
        end
        if (dma_done) done_cyc.push_back(cyc);
        if (dma_hdr_err) hdr_ever = 1'b1;
        if (!dma_busy) begin
            n_rd = 0;
            n_push = 0;
        end else begin
            n_rd += int'(rom_rd_en);
            n_push += int'(push);
            if (n_rd - n_push > LAT + 1) viol++;
        end
    end

    function automatic void clear_mon();
        got.delete(); addrs.delete(); push_cyc.delete(); rd_cyc.delete();
        done_cyc.delete(); hdr_seen.delete();
        hdr_ever = 1'b0;
        viol = 0;
    endfunction

    function automatic void build_exp(input logic [AW-1:0] b, input int n);
        exp_q.delete(); exp_a.delete();
        for (int i = 0; i < n * NI; i++) begin
            exp_a.push_back(b + AW'(i));
            exp_q.push_back(mem[b + AW'(i)]);
        end
    endfunction

    task automatic start_xfer(input logic [AW-1:0] b, input int n, output int k);
        @(posedge clk); #1;
        clear_mon();
        dma_base_addr = b;
        dma_num_inst = NW'(n);
        dma_start = 1'b1;
        k = cyc;
        @(posedge clk); #1;
        dma_start = 1'b0;
    endtask

    // mode 0: no back-pressure, 1: full in cycles k+4..k+12, 2: random full and stray starts
    task automatic run_until_done(input int k, input int mode, input int budget, output int ok);
        ok = 0;
        for (int i = 0; i < budget && ok == 0; i++) begin
            full = (mode == 1) ? (cyc >= k + 4 && cyc <= k + 12) : (mode == 2) ? ($urandom % 3 == 0) : 1'b0;
            if (mode == 2) begin
                dma_start = ($urandom % 8 == 0);
                dma_base_addr = AW'($urandom);
                dma_num_inst = NW'($urandom);
            end
            if (dma_done) ok = 1;
            @(posedge clk); #1;
        end
        full = 1'b0;
        dma_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({dma_busy, dma_done, dma_hdr_err, rom_rd_en, push} !== 5'b0)
            begin errors++; $display("FAIL reset_ctl: got %b want 00000", {dma_busy, dma_done, dma_hdr_err, rom_rd_en, push}); end
        checks++;
        if (rom_addr !== '0) begin errors++; $display("FAIL reset_addr: got %h want 000", rom_addr); end
        checks++;
        if (fifo_din !== '0) begin errors++; $display("FAIL reset_din: got %h want 00", fifo_din); end
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (dma_busy !== 1'b0 || rom_rd_en !== 1'b0) begin errors++; $display("FAIL idle_quiet: busy %b rd %b want 0 0", dma_busy, rom_rd_en); end
    endtask

    task automatic test_basic();
        int k, ok;
        for (int a = 0; a < (1 << AW); a++) mem[a] = DW'(a);
        start_xfer(10'h010, 2, k);
        run_until_done(k, 0, 100, ok);
        build_exp(10'h010, 2);
        checks++;
        if (ok == 0) begin errors++; $display("FAIL basic_timeout: done not seen"); end
        checks++;
        if (got.size() != 10) begin errors++; $display("FAIL basic_count: got %0d want 10", got.size()); end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin errors++; $display("FAIL basic_byte%0d: got %h want %h", i, got[i], exp_q[i]); end
        end
        if (got.size() == 10 && rd_cyc.size() != 0) begin
            checks++;
            if (rd_cyc[0] != k + 1) begin errors++; $display("FAIL basic_first_rd: got cyc %0d want %0d", rd_cyc[0], k + 1); end
            checks++;
            if (push_cyc[0] != rd_cyc[0] + LAT + 1) begin errors++; $display("FAIL basic_latency: got %0d want %0d", push_cyc[0] - rd_cyc[0], LAT + 1); end
            checks++;
            if (push_cyc[9] - push_cyc[0] != 9) begin errors++; $display("FAIL basic_rate: got span %0d want 9", push_cyc[9] - push_cyc[0]); end
            checks++;
            if (done_cyc.size() != 1 || done_cyc[0] != push_cyc[9] + 1)
                begin errors++; $display("FAIL basic_done: got %0d pulses want 1 at %0d", done_cyc.size(), push_cyc[9] + 1); end
        end
    endtask

    task automatic test_wrap();
        int k, ok;
        for (int a = 0; a < (1 << AW); a++) mem[a] = DW'($urandom);
        start_xfer(10'h3FE, 1, k);
        run_until_done(k, 0, 100, ok);
        build_exp(10'h3FE, 1);
        checks++;
        if (ok == 0 || addrs.size() != 5 || got.size() != 5)
            begin errors++; $display("FAIL wrap_count: done %0d addrs %0d bytes %0d want 1 5 5", ok, addrs.size(), got.size()); end
        for (int i = 0; i < addrs.size() && i < 5; i++) begin
            checks++;
            if (addrs[i] !== exp_a[i]) begin errors++; $display("FAIL wrap_addr%0d: got %h want %h", i, addrs[i], exp_a[i]); end
        end
        for (int i = 0; i < got.size() && i < 5; i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin errors++; $display("FAIL wrap_byte%0d: got %h want %h", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_backpressure();
        int k, ok, after;
        logic [AW-1:0] b;
        b = AW'($urandom);
        start_xfer(b, 3, k);
        run_until_done(k, 1, 200, ok);
        build_exp(b, 3);
        checks++;
        if (ok == 0) begin errors++; $display("FAIL bp_timeout: done not seen"); end
        checks++;
        if (viol != 0) begin errors++; $display("FAIL bp_protocol: got %0d violations want 0", viol); end
        checks++;
        if (got.size() != 15) begin errors++; $display("FAIL bp_count: got %0d want 15", got.size()); end
        for (int i = 0; i < got.size() && i < 15; i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin errors++; $display("FAIL bp_byte%0d: got %h want %h", i, got[i], exp_q[i]); end
        end
        if (got.size() == 15) begin
            after = 0;
            foreach (push_cyc[i]) if (push_cyc[i] >= k + 13) after++;
            checks++;
            if (after != push_cyc[14] - (k + 13) + 1)
                begin errors++; $display("FAIL bp_resume: got %0d pushes want %0d", after, push_cyc[14] - (k + 13) + 1); end
            checks++;
            if (done_cyc.size() != 1 || done_cyc[0] != push_cyc[14] + 1)
                begin errors++; $display("FAIL bp_done: got %0d pulses want 1 at %0d", done_cyc.size(), push_cyc[14] + 1); end
        end
    endtask

    task automatic test_zero();
        int k, ok;
        start_xfer(AW'($urandom), 0, k);
        run_until_done(k, 0, 20, ok);
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] != k + 1)
            begin errors++; $display("FAIL zero_done: got %0d pulses want 1 at %0d", done_cyc.size(), k + 1); end
        checks++;
        if (rd_cyc.size() != 0 || got.size() != 0)
            begin errors++; $display("FAIL zero_activity: got %0d reads %0d pushes want 0 0", rd_cyc.size(), got.size()); end
    endtask

    task automatic test_abort();
        int k, ok, cnt, ab, late;
        cnt = 0;
        ab = -1;
        for (int a = 0; a < (1 << AW); a++) mem[a] = DW'(a);
        start_xfer(10'h200, 4, k);
        build_exp(10'h200, 4);
        for (int i = 0; i < 50 && ab < 0; i++) begin
            if (rom_rd_en) begin
                cnt++;
                if (cnt == 7) begin dma_abort = 1'b1; ab = cyc; end
            end
            @(posedge clk); #1;
        end
        dma_abort = 1'b0;
        checks++;
        if (ab < 0) begin errors++; $display("FAIL abort_timeout: 7th issue not seen"); end
        checks++;
        if (dma_busy !== 1'b0 || rom_rd_en !== 1'b0 || push !== 1'b0)
            begin errors++; $display("FAIL abort_next: busy %b rd %b push %b want 0 0 0", dma_busy, rom_rd_en, push); end
        repeat (8) @(posedge clk);
        #1;
        late = 0;
        foreach (push_cyc[i]) if (push_cyc[i] > ab) late++;
        checks++;
        if (late != 0 || rd_cyc.size() != 7)
            begin errors++; $display("FAIL abort_stop: got %0d late pushes %0d reads want 0 7", late, rd_cyc.size()); end
        checks++;
        if (done_cyc.size() != 0) begin errors++; $display("FAIL abort_nodone: got %0d pulses want 0", done_cyc.size()); end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin errors++; $display("FAIL abort_prefix%0d: got %h want %h", i, got[i], exp_q[i]); end
        end
        start_xfer(10'h100, 1, k);
        run_until_done(k, 0, 100, ok);
        checks++;
        if (ok == 0 || got.size() != 5 || done_cyc.size() != 1)
            begin errors++; $display("FAIL restart_count: done %0d bytes %0d want 1 5", done_cyc.size(), got.size()); end
        for (int i = 0; i < got.size() && i < 5; i++) begin
            checks++;
            if (got[i] !== DW'(i)) begin errors++; $display("FAIL restart_byte%0d: got %h want %h", i, got[i], DW'(i)); end
        end
    endtask

    task automatic test_abort_start();
        @(posedge clk); #1;
        clear_mon();
        dma_base_addr = AW'($urandom);
        dma_num_inst = 8'd2;
        dma_start = 1'b1;
        dma_abort = 1'b1;
        @(posedge clk); #1;
        dma_start = 1'b0;
        dma_abort = 1'b0;
        checks++;
        if (dma_busy !== 1'b0 || dma_done !== 1'b0) begin errors++; $display("FAIL abort_wins: busy %b done %b want 0 0", dma_busy, dma_done); end
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (rd_cyc.size() != 0 || done_cyc.size() != 0)
            begin errors++; $display("FAIL abort_wins_quiet: got %0d reads %0d done want 0 0", rd_cyc.size(), done_cyc.size()); end
    endtask

    task automatic test_reset_mid();
        int k;
        start_xfer(AW'($urandom), 3, k);
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({dma_busy, dma_done, dma_hdr_err, rom_rd_en, push} !== 5'b0)
            begin errors++; $display("FAIL midreset: got %b want 00000", {dma_busy, dma_done, dma_hdr_err, rom_rd_en, push}); end
        reset_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (done_cyc.size() != 0 || dma_busy !== 1'b0)
            begin errors++; $display("FAIL midreset_quiet: done %0d busy %b want 0 0", done_cyc.size(), dma_busy); end
    endtask

    task automatic test_back_to_back();
        int k, ok, n, bad;
        logic [AW-1:0] b;
        for (int a = 0; a < (1 << AW); a++) mem[a] = DW'($urandom);
        for (int t = 0; t < 8; t++) begin
            b = AW'($urandom);
            n = 1 + int'($urandom % 6);
            start_xfer(b, n, k);
            run_until_done(k, 2, 400, ok);
            build_exp(b, n);
            bad = 0;
            for (int i = 0; i < got.size() && i < exp_q.size(); i++) if (got[i] !== exp_q[i]) bad++;
            for (int i = 0; i < addrs.size() && i < exp_a.size(); i++) if (addrs[i] !== exp_a[i]) bad++;
            checks++;
            if (ok == 0 || got.size() != exp_q.size() || addrs.size() != exp_a.size() || bad != 0)
                begin errors++; $display("FAIL b2b%0d_data: done %0d bytes %0d/%0d reads %0d mismatches %0d", t, ok, got.size(), exp_q.size(), addrs.size(), bad); end
            checks++;
            if (viol != 0) begin errors++; $display("FAIL b2b%0d_protocol: got %0d violations want 0", t, viol); end
            if (push_cyc.size() != 0) begin
                checks++;
                if (done_cyc.size() != 1 || done_cyc[0] != push_cyc[push_cyc.size()-1] + 1)
                    begin errors++; $display("FAIL b2b%0d_done: got %0d pulses want 1 after last push", t, done_cyc.size()); end
            end
        end
    endtask

    task automatic test_hdr();
        int k, ok;
        logic [AW-1:0] b;
        b = 10'h050;
        for (int i = 0; i < 15; i++)
            mem[b + AW'(i)] = (i % NI == 0) ? {1'b0, 3'($urandom % 3), 4'($urandom)} : DW'($urandom);
        mem[b + AW'(5)] = 8'h35;
        start_xfer(b, 2, k);
        run_until_done(k, 0, 100, ok);
        checks++;
        if (ok == 0 || got.size() != 10) begin errors++; $display("FAIL hdr_count: done %0d bytes %0d want 1 10", ok, got.size()); end
        if (got.size() == 10) begin
            checks++;
            if (got[5] !== 8'h35) begin errors++; $display("FAIL hdr_passthru: got %h want 35", got[5]); end
`ifdef ROM_DMA_HDR_CHK_EN
            checks++;
            if (hdr_seen[4] !== 1'b0 || hdr_seen[5] !== 1'b0 || hdr_seen[6] !== 1'b1)
                begin errors++; $display("FAIL hdr_rise: got %b%b%b want 001", hdr_seen[4], hdr_seen[5], hdr_seen[6]); end
            checks++;
            if (dma_hdr_err !== 1'b1) begin errors++; $display("FAIL hdr_sticky: got %b want 1", dma_hdr_err); end
`else
            checks++;
            if (hdr_ever !== 1'b0) begin errors++; $display("FAIL hdr_tied: got %b want 0", hdr_ever); end
`endif
        end
        start_xfer(b + AW'(10), 1, k);
        checks++;
        if (dma_hdr_err !== 1'b0) begin errors++; $display("FAIL hdr_clear: got %b want 0", dma_hdr_err); end
        run_until_done(k, 0, 100, ok);
        checks++;
        if (ok == 0 || dma_hdr_err !== 1'b0) begin errors++; $display("FAIL hdr_clean: done %0d err %b want 1 0", ok, dma_hdr_err); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero();
        test_abort();
        test_abort_start();
        test_reset_mid();
        test_back_to_back();
        test_hdr();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
